mem_ctrl: RTL and testbench

Memory controller directly downstream of the data cache and instruction fetch. It takes 32-bit word requests from two ports, the data cache and IF, and arbitrates between them. Each winning request is turned into four byte accesses on the 8-bit synchronous RAM bus. For each request it returns the assembled word together with a one-cycle ready pulse, which drives the cache's `ram_data_i`/`ram_data_ready` and the IF equivalents.

---
 rtl/mem_ctrl_pkg.sv | 30 +++
 rtl/mem_ctrl_if.sv | 49 ++++
 rtl/mem_ctrl_arb.sv | 31 +++
 rtl/mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared constants and types for the word-to-byte memory controller.
// Optional feature macro: MEM_CTRL_RR_ARB_EN (round-robin arbitration).
package mem_ctrl_pkg;

  // Controller FSM encodings.
  typedef enum logic [1:0] {
    MemCtrlIdle = 2'd0,
    MemCtrlXfer = 2'd1,
    MemCtrlDone = 2'd2
  } mem_ctrl_state_t;

  // Default RAM byte-address width.
  localparam int MemCtrlAddrBus = 17;

  // Requesting-port identifiers.
  localparam logic PortDc = 1'b0;
  localparam logic PortIf = 1'b1;

  // Common control levels and constants.
  localparam logic        RstEnable   = 1'b1;
  localparam logic        ChipEnable  = 1'b1;
  localparam logic        WriteEnable = 1'b1;
  localparam logic [31:0] ZeroWord    = 32'h0000_0000;

  // Little-endian byte lane idx of a 32-bit word.
  function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Bundle of the data-cache port, the instruction-fetch port and the 8-bit RAM bus.
// slave = controller side, master = requesters plus RAM side.
// Optional feature macro: MEM_CTRL_RR_ARB_EN (does not change this bundle).
interface mem_ctrl_if
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = MemCtrlAddrBus
) ();

  // Data-cache port
  logic                  dc_ce_i;
  logic                  dc_we_i;
  logic [3:0]            dc_sel_i;
  logic [31:0]           dc_addr_i;
  logic [31:0]           dc_data_i;
  logic [31:0]           dc_data_o;
  logic                  dc_ready_o;

  // Instruction-fetch port
  logic                  if_ce_i;
  logic [31:0]           if_addr_i;
  logic [31:0]           if_data_o;
  logic                  if_ready_o;

  // RAM bus
  logic [ADDR_WIDTH-1:0] ram_a_o;
  logic                  ram_wr_o;
  logic [7:0]            ram_dout_o;
  logic [7:0]            ram_din_i;

  modport slave (
    input  dc_ce_i, dc_we_i, dc_sel_i, dc_addr_i, dc_data_i,
    output dc_data_o, dc_ready_o,
    input  if_ce_i, if_addr_i,
    output if_data_o, if_ready_o,
    output ram_a_o, ram_wr_o, ram_dout_o,
    input  ram_din_i
  );

  modport master (
    output dc_ce_i, dc_we_i, dc_sel_i, dc_addr_i, dc_data_i,
    input  dc_data_o, dc_ready_o,
    output if_ce_i, if_addr_i,
    input  if_data_o, if_ready_o,
    input  ram_a_o, ram_wr_o, ram_dout_o,
    output ram_din_i
  );

endinterface

// File: rtl/mem_ctrl_arb.sv
// Combinational grant between the data-cache and instruction-fetch requesters.
// Default: fixed priority, data cache first.
// With MEM_CTRL_RR_ARB_EN: on a tie the port that was not served last wins.
module mem_ctrl_arb
  import mem_ctrl_pkg::*;
(
  input  logic dc_ce,
  input  logic if_ce,
`ifdef MEM_CTRL_RR_ARB_EN
  input  logic last,
`endif
  output logic grant_valid,
  output logic grant_port
);

  // Pick a winner whenever at least one port requests.
  always_comb begin
    grant_valid = (dc_ce == ChipEnable) || (if_ce == ChipEnable);
    grant_port  = PortDc;
    if ((dc_ce == ChipEnable) && (if_ce == ChipEnable)) begin
`ifdef MEM_CTRL_RR_ARB_EN
      grant_port = (last == PortDc) ? PortIf : PortDc;
`else
      grant_port = PortDc;
`endif
    end else if (if_ce == ChipEnable) begin
      grant_port = PortIf;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates word requests from the data cache and
// instruction fetch and splits each into four byte slots on the RAM bus.
// Optional feature macro: MEM_CTRL_RR_ARB_EN (round-robin arbitration with a
// one-bit record of the last served port).
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = MemCtrlAddrBus
) (
  input logic       clk,
  input logic       rst,
  mem_ctrl_if.slave bus
);

  mem_ctrl_state_t       state_reg, state_next;
  logic [1:0]            cnt_reg;
  logic                  port_reg;
  logic                  we_reg;
  logic [3:0]            sel_reg;
  logic [ADDR_WIDTH-3:0] base_reg;
  logic [31:0]           wdata_reg;
  logic [23:0]           rdata_word;
  logic                  dc_ready_reg, if_ready_reg;
  logic [31:0]           dc_data_reg, if_data_reg;
  logic [31:0]           done_word;
  logic                  grant_valid, grant_port;
  logic                  in_xfer;

`ifdef MEM_CTRL_RR_ARB_EN
  logic last_reg;

  // Remember which port won the most recent arbitration.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      last_reg <= PortIf;
    end else if ((state_reg == MemCtrlIdle) && grant_valid) begin
      last_reg <= grant_port;
    end
  end

  mem_ctrl_arb u_arb (
    .dc_ce       (bus.dc_ce_i),
    .if_ce       (bus.if_ce_i),
    .last        (last_reg),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );
`else
  mem_ctrl_arb u_arb (
    .dc_ce       (bus.dc_ce_i),
    .if_ce       (bus.if_ce_i),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state_reg <= MemCtrlIdle;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: IDLE -> XFER (four slots) -> DONE -> IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MemCtrlIdle: if (grant_valid) state_next = MemCtrlXfer;
      MemCtrlXfer: if (cnt_reg == 2'd3) state_next = MemCtrlDone;
      MemCtrlDone: state_next = MemCtrlIdle;
      default:     state_next = MemCtrlIdle;
    endcase
  end

  // Latch the winning request in IDLE and step the byte counter in XFER.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      cnt_reg   <= 2'd0;
      port_reg  <= PortDc;
      we_reg    <= 1'b0;
      sel_reg   <= 4'b0000;
      base_reg  <= '0;
      wdata_reg <= ZeroWord;
    end else if (state_reg == MemCtrlIdle) begin
      cnt_reg <= 2'd0;
      if (grant_valid) begin
        port_reg <= grant_port;
        if (grant_port == PortDc) begin
          we_reg    <= (bus.dc_we_i == WriteEnable);
          sel_reg   <= bus.dc_sel_i;
          base_reg  <= bus.dc_addr_i[ADDR_WIDTH-1:2];
          wdata_reg <= bus.dc_data_i;
        end else begin
          we_reg    <= 1'b0;
          sel_reg   <= 4'b0000;
          base_reg  <= bus.if_addr_i[ADDR_WIDTH-1:2];
          wdata_reg <= ZeroWord;
        end
      end
    end else if (state_reg == MemCtrlXfer) begin
      cnt_reg <= cnt_reg + 2'd1;
    end
  end

  // Read bytes 0..2 arrive one cycle after their slot, i.e. while cnt = k+1.
  // Byte 3 arrives during DONE and is forwarded straight into done_word.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rd_byte
    logic [7:0] byte_reg;

    // Capture read byte gi.
    always_ff @(posedge clk) begin
      if (rst == RstEnable) begin
        byte_reg <= 8'h00;
      end else if ((state_reg == MemCtrlXfer) && (cnt_reg == 2'(gi + 1))) begin
        byte_reg <= bus.ram_din_i;
      end
    end

    assign rdata_word[8*gi +: 8] = byte_reg;
  end

  // Word presented on completion; writes complete with zero data.
  assign done_word = we_reg ? ZeroWord : {bus.ram_din_i, rdata_word};

  // Completion pulses (high during DONE) and per-port held result words.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      dc_ready_reg <= 1'b0;
      if_ready_reg <= 1'b0;
      dc_data_reg  <= ZeroWord;
      if_data_reg  <= ZeroWord;
    end else begin
      dc_ready_reg <= 1'b0;
      if_ready_reg <= 1'b0;
      if ((state_reg == MemCtrlXfer) && (cnt_reg == 2'd3)) begin
        if (port_reg == PortDc) dc_ready_reg <= 1'b1;
        else                    if_ready_reg <= 1'b1;
      end
      if (state_reg == MemCtrlDone) begin
        if (port_reg == PortDc) dc_data_reg <= done_word;
        else                    if_data_reg <= done_word;
      end
    end
  end

  // During the ready cycle the last byte is still on ram_din_i, so the
  // assembled word is forwarded; afterwards the held register takes over.
  assign bus.dc_ready_o = dc_ready_reg;
  assign bus.if_ready_o = if_ready_reg;
  assign bus.dc_data_o  = dc_ready_reg ? done_word : dc_data_reg;
  assign bus.if_data_o  = if_ready_reg ? done_word : if_data_reg;

  // RAM bus driven directly from transfer state; writes are suppressed while
  // rst is high so an abandoned transfer stops at the reset edge.
  assign in_xfer        = (state_reg == MemCtrlXfer);
  assign bus.ram_a_o    = in_xfer ? {base_reg, cnt_reg} : '0;
  assign bus.ram_wr_o   = in_xfer && we_reg && sel_reg[cnt_reg] && (rst != RstEnable);
  assign bus.ram_dout_o = (in_xfer && we_reg) ? byte_of(wdata_reg, cnt_reg) : 8'h00;

  // Address bits outside the RAM word address are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.dc_addr_i[31:ADDR_WIDTH], bus.dc_addr_i[1:0],
                              bus.if_addr_i[31:ADDR_WIDTH], bus.if_addr_i[1:0]};

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a byte RAM model and a per-port
// scoreboard of expected completion words and cycles.
// Optional feature macro: MEM_CTRL_RR_ARB_EN (changes the second-tie winner).
module tb_mem_ctrl;

  localparam int AW = 17;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  exp_t q_dc[$];
  exp_t q_if[$];

  logic [7:0]    mem [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_word = '0;

  mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  mem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM with one-cycle read latency plus a word-wide backdoor loader.
  always @(posedge clk) begin
    if (bus.ram_wr_o) mem[bus.ram_a_o] <= bus.ram_dout_o;
    bus.ram_din_i <= mem[bus.ram_a_o];
    if (bd_we) begin
      for (int k = 0; k < 4; k++) mem[bd_addr + AW'(k)] <= bd_word[8*k +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ready pulse pops the oldest expectation of its port.
  always @(negedge clk) begin
    exp_t e;
    if (bus.dc_ready_o) begin
      if (q_dc.size() == 0) begin
        check("dc_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = q_dc.pop_front();
        check("dc_data", bus.dc_data_o, e.data);
        check("dc_ready_cycle", 32'(cyc), 32'(e.cyc));
        $display("dc completion: data %h at cycle %0d", bus.dc_data_o, cyc);
      end
    end
    if (bus.if_ready_o) begin
      if (q_if.size() == 0) begin
        check("if_unexpected_ready", 32'd1, 32'd0);
      end else begin
        e = q_if.pop_front();
        check("if_data", bus.if_data_o, e.data);
        check("if_ready_cycle", 32'(cyc), 32'(e.cyc));
        $display("if completion: data %h at cycle %0d", bus.if_data_o, cyc);
      end
    end
  end

  task automatic bd_write(input logic [AW-1:0] a, input logic [31:0] w);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_word = w;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // Wait (bounded) for all expected completions, then settle into IDLE.
  task automatic drain();
    int i = 0;
    while ((q_dc.size() != 0 || q_if.size() != 0) && i < 40) begin
      @(negedge clk);
      i++;
    end
    check("drain_pending", 32'(q_dc.size() + q_if.size()), 32'd0);
    q_dc.delete();
    q_if.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int c;
    bus.dc_ce_i = 1'b0; bus.dc_we_i = 1'b0; bus.dc_sel_i = 4'h0;
    bus.dc_addr_i = '0; bus.dc_data_i = '0;
    bus.if_ce_i = 1'b0; bus.if_addr_i = '0;

    // Preload RAM while held in reset.
    bd_write(17'h00000, 32'hDEADBEEF);
    bd_write(17'h00004, 32'h40302010);
    bd_write(17'h00010, 32'h04030201);
    bd_write(17'h00104, 32'h44332211);
    bd_write(17'h00200, 32'h55555555);
    bd_write(17'h00300, 32'h00000000);
    @(negedge clk);
    rst = 1'b0;

    // Reset state of all outputs.
    check("rst_ram_a", 32'(bus.ram_a_o), 32'd0);
    check("rst_ram_wr", 32'(bus.ram_wr_o), 32'd0);
    check("rst_ram_dout", 32'(bus.ram_dout_o), 32'd0);
    check("rst_dc_ready", 32'(bus.dc_ready_o), 32'd0);
    check("rst_if_ready", 32'(bus.if_ready_o), 32'd0);
    check("rst_dc_data", bus.dc_data_o, 32'd0);
    check("rst_if_data", bus.if_data_o, 32'd0);
    @(negedge clk);

    // Tie 1: dc wins, IF follows six cycles later.
    c = cyc;
    bus.dc_ce_i = 1'b1; bus.dc_we_i = 1'b0; bus.dc_addr_i = 32'h0000_0010;
    bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h0000_0000;
    q_dc.push_back('{32'h04030201, c + 5});
    q_if.push_back('{32'hDEADBEEF, c + 11});
    @(negedge clk);
    bus.dc_ce_i = 1'b0;
    repeat (6) @(negedge clk);
    bus.if_ce_i = 1'b0;
    drain();

    // Tie 2 with both held across the first completion.
    c = cyc;
    bus.dc_ce_i = 1'b1; bus.if_ce_i = 1'b1;
    q_dc.push_back('{32'h04030201, c + 5});
`ifdef MEM_CTRL_RR_ARB_EN
    q_if.push_back('{32'hDEADBEEF, c + 11});
`else
    q_dc.push_back('{32'h04030201, c + 11});
`endif
    repeat (7) @(negedge clk);
    bus.dc_ce_i = 1'b0; bus.if_ce_i = 1'b0;
    drain();

    // dc read 0x104: slots walk 0x104..0x107.
    c = cyc;
    bus.dc_ce_i = 1'b1; bus.dc_we_i = 1'b0; bus.dc_addr_i = 32'h0000_0104;
    q_dc.push_back('{32'h44332211, c + 5});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.dc_ce_i = 1'b0;
      check("rd_ram_a", 32'(bus.ram_a_o), 32'h104 + 32'(k));
    end
    drain();

    // dc write 0x200, sel 0101: only bytes 0 and 2 are strobed.
    c = cyc;
    bus.dc_ce_i = 1'b1; bus.dc_we_i = 1'b1; bus.dc_sel_i = 4'b0101;
    bus.dc_addr_i = 32'h0000_0200; bus.dc_data_i = 32'hA1B2C3D4;
    q_dc.push_back('{32'h0, c + 5});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.dc_ce_i = 1'b0;
      check("wr_ram_wr", 32'(bus.ram_wr_o), (k % 2 == 0) ? 32'd1 : 32'd0);
    end
    drain();
    check("wr_mem_200", 32'(mem[17'h200]), 32'hD4);
    check("wr_mem_201", 32'(mem[17'h201]), 32'h55);
    check("wr_mem_202", 32'(mem[17'h202]), 32'hB2);
    check("wr_mem_203", 32'(mem[17'h203]), 32'h55);

    // Address truncation: 0x00020007 maps to RAM 0x04..0x07.
    c = cyc;
    bus.dc_ce_i = 1'b1; bus.dc_we_i = 1'b0; bus.dc_addr_i = 32'h0002_0007;
    q_dc.push_back('{32'h40302010, c + 5});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.dc_ce_i = 1'b0;
      check("trunc_ram_a", 32'(bus.ram_a_o), 32'h4 + 32'(k));
    end
    drain();

    // IF held high: back-to-back fetches; RAM word changed between them.
    c = cyc;
    bus.if_ce_i = 1'b1; bus.if_addr_i = 32'h0000_0000;
    q_if.push_back('{32'hDEADBEEF, c + 5});
    q_if.push_back('{32'h11223344, c + 11});
    repeat (5) @(negedge clk);
    bd_we = 1'b1; bd_addr = 17'h0; bd_word = 32'h11223344;
    for (int k = 6; k <= 10; k++) begin
      @(negedge clk);
      bd_we = 1'b0;
      if (k == 7) bus.if_ce_i = 1'b0;
      check("if_data_hold", bus.if_data_o, 32'hDEADBEEF);
    end
    drain();

    // Reset in cycle 3 of a full write: bytes 0,1 land, 2,3 do not.
    c = cyc;
    bus.dc_ce_i = 1'b1; bus.dc_we_i = 1'b1; bus.dc_sel_i = 4'b1111;
    bus.dc_addr_i = 32'h0000_0300; bus.dc_data_i = 32'h9A8B7C6D;
    @(negedge clk);
    bus.dc_ce_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstx_ram_wr", 32'(bus.ram_wr_o), 32'd0);
    check("rstx_ram_a", 32'(bus.ram_a_o), 32'd0);
    check("rstx_ram_dout", 32'(bus.ram_dout_o), 32'd0);
    check("rstx_dc_ready", 32'(bus.dc_ready_o), 32'd0);
    check("rstx_dc_data", bus.dc_data_o, 32'd0);
    check("rstx_if_data", bus.if_data_o, 32'd0);
    repeat (10) @(negedge clk);
    check("rstx_mem_300", 32'(mem[17'h300]), 32'h6D);
    check("rstx_mem_301", 32'(mem[17'h301]), 32'h7C);
    check("rstx_mem_302", 32'(mem[17'h302]), 32'h00);
    check("rstx_mem_303", 32'(mem[17'h303]), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
